// File: rtl/sfp_tx_arbiter.sv
// sfp_tx_arbiter: round-robin packet arbiter sharing one 64-bit SFP/Aurora TX
// AXI-Stream between N_SRC packet sources. One whole packet is granted at a time.
// The grant is withheld while the channel is down. A packet is aborted if its
// source stalls for too long or if the channel drops.
//
// Build option: define SFP_ARB_PRIO0_EN to give source 0 strict priority at
// arbitration time. A packet already in progress is never pre-empted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; pick the next requester when the channel is up
//   XFER  | one source owns the link until tlast, stall timeout or drop

module sfp_tx_arbiter #(
    parameter int N_SRC       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_channel_up,
    input  logic [N_SRC*64-1:0]  s_tdata,
    input  logic [N_SRC-1:0]     s_tvalid,
    input  logic [N_SRC-1:0]     s_tlast,
    output logic [N_SRC-1:0]     s_tready,
    output logic [63:0]          m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [N_SRC-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic                 o_abort,
    output logic [CNT_W-1:0]     o_pkt_cnt
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  gnt_idx_nxt;
    logic [IDX_W-1:0]  gnt_inc;
    logic [N_SRC-1:0]  grant_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_ptr_nxt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_nxt;
    logic [CNT_W-1:0]  pkt_cnt_nxt;
    logic              timeout_nxt;
    logic              abort_nxt;

    logic              xfer;
    logic              src_valid;
    logic              src_last;
    logic [63:0]       src_data;
    logic              beat_acc;

    // Arbitration: first requester at or above the rr pointer, wrapping around.
    // A source only counts as requesting while the channel is up.
    always_comb begin
        int k;
        logic [IDX_W-1:0] cand;
        k        = 0;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N_SRC) begin
                k = k - N_SRC;
            end
            cand = IDX_W'(k);
            if (!pick_vld && i_channel_up && s_tvalid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
`ifdef SFP_ARB_PRIO0_EN
        if (i_channel_up && s_tvalid[0]) begin
            pick_vld = 1'b1;
            pick_idx = '0;
        end
`endif
    end

    // Granted source's signals and the index that follows it in rotation.
    always_comb begin
        src_valid = s_tvalid[gnt_idx];
        src_last  = s_tlast[gnt_idx];
        src_data  = s_tdata[{gnt_idx, 6'b0} +: 64];
        gnt_inc   = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
    end

    // State register plus the registered grant, pointer, counters and pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            o_grant   <= '0;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            o_pkt_cnt <= '0;
            o_timeout <= 1'b0;
            o_abort   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_idx   <= gnt_idx_nxt;
            o_grant   <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            o_pkt_cnt <= pkt_cnt_nxt;
            o_timeout <= timeout_nxt;
            o_abort   <= abort_nxt;
        end
    end

    // Next-state logic. Channel drop is checked first. An accepted beat needs
    // the channel up, so completion and abort can never coincide.
    always_comb begin
        state_nxt   = state;
        gnt_idx_nxt = gnt_idx;
        grant_nxt   = o_grant;
        rr_ptr_nxt  = rr_ptr;
        tmo_cnt_nxt = tmo_cnt;
        pkt_cnt_nxt = o_pkt_cnt;
        timeout_nxt = 1'b0;
        abort_nxt   = 1'b0;
        case (state)
            IDLE: begin
                tmo_cnt_nxt = '0;
                grant_nxt   = '0;
                if (pick_vld) begin
                    state_nxt   = XFER;
                    gnt_idx_nxt = pick_idx;
                    grant_nxt   = N_SRC'(1) << pick_idx;
                end
            end
            XFER: begin
                if (!i_channel_up) begin
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    rr_ptr_nxt  = gnt_inc;
                    tmo_cnt_nxt = '0;
                    abort_nxt   = 1'b1;
                end else if (beat_acc) begin
                    tmo_cnt_nxt = '0;
                    if (src_last) begin
                        state_nxt   = IDLE;
                        grant_nxt   = '0;
                        rr_ptr_nxt  = gnt_inc;
                        pkt_cnt_nxt = o_pkt_cnt + 1'b1;
                    end
                end else if (!src_valid) begin
                    if (tmo_cnt == TMO_LAST) begin
                        state_nxt   = IDLE;
                        grant_nxt   = '0;
                        rr_ptr_nxt  = gnt_inc;
                        tmo_cnt_nxt = '0;
                        timeout_nxt = 1'b1;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Output logic: zero-latency pass-through of the granted source in XFER.
    always_comb begin
        xfer     = (state == XFER);
        o_busy   = xfer;
        m_tvalid = xfer & src_valid & i_channel_up;
        m_tlast  = src_last & m_tvalid;
        m_tdata  = xfer ? src_data : 64'd0;
        beat_acc = m_tvalid & m_tready;
        s_tready = '0;
        if (xfer) begin
            s_tready[gnt_idx] = m_tready & i_channel_up;
        end
    end

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// Directed bench for sfp_tx_arbiter (N_SRC=4, TIMEOUT_CYC=16).
// Expected values are hand-derived and checked with immediate assertions.

module tb_sfp_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int CW  = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_channel_up;
    logic [N*64-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [63:0]     m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic            o_timeout;
    logic            o_abort;
    logic [CW-1:0]   o_pkt_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    sfp_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_channel_up(i_channel_up),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout), .o_abort(o_abort),
        .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bval(input int s, input int b);
        return 64'hA5A5_0000_0000_0000 | (64'(s) << 8) | 64'(b);
    endfunction

    task automatic set_data(input int s, input logic [63:0] v);
        s_tdata[s*64 +: 64] = v;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic bad_to, bad_data, bad_rdy, bad_busy, bad_gnt;
        int   exp_cnt;
        int   s;
        logic [N-1:0] exp_g;

        i_rst = 1'b0; i_channel_up = 1'b0; s_tdata = '0; s_tvalid = '0;
        s_tlast = '0; m_tready = 1'b0; exp_cnt = 0;

        // Reset values
        #12;
        chk("rst_grant",   64'(o_grant),   64'd0);
        chk("rst_busy",    64'(o_busy),    64'd0);
        chk("rst_timeout", 64'(o_timeout), 64'd0);
        chk("rst_abort",   64'(o_abort),   64'd0);
        chk("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast",  64'(m_tlast),  64'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        step();

        // Single packet from src1: A, B, C
        i_channel_up = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0010; set_data(1, 64'hA);
        #1;
        chk("sp_idle_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("sp_idle_grant",    64'(o_grant),  64'd0);
        step();
        chk("sp_grant",    64'(o_grant),  64'b0010);
        chk("sp_busy",     64'(o_busy),   64'd1);
        chk("sp_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("sp_data_a",   m_tdata,       64'hA);
        chk("sp_s_tready", 64'(s_tready), 64'b0010);
        step();
        set_data(1, 64'hB);
        #1;
        chk("sp_data_b", m_tdata, 64'hB);
        step();
        set_data(1, 64'hC); s_tlast[1] = 1'b1;
        #1;
        chk("sp_data_c",  m_tdata,       64'hC);
        chk("sp_m_tlast", 64'(m_tlast),  64'd1);
        step();
        exp_cnt = 1;
        chk("sp_grant_rel", 64'(o_grant),   64'd0);
        chk("sp_busy_rel",  64'(o_busy),    64'd0);
        chk("sp_pkt_cnt",   64'(o_pkt_cnt), 64'(exp_cnt));
        s_tvalid = '0; s_tlast = '0;

        // Reset to bring the rr pointer back to 0
        i_rst = 1'b0;
        #1;
        chk("rst2_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
        exp_cnt = 0;
        @(negedge i_clk);
        i_rst = 1'b1;
        step();

        // Fairness: all sources request 2-beat packets continuously
        s_tvalid = 4'b1111;
        for (int k = 0; k < N; k++) set_data(k, bval(k, 0));
        for (int p = 0; p < 5; p++) begin
            s = p % N;
            exp_g = 4'b0001 << s;
            step();
            chk("fair_grant", 64'(o_grant), 64'(exp_g));
            chk("fair_beat0", m_tdata, bval(s, 0));
            step();
            s_tlast[s] = 1'b1; set_data(s, bval(s, 1));
            #1;
            chk("fair_beat1", m_tdata, bval(s, 1));
            chk("fair_tlast", 64'(m_tlast), 64'd1);
            step();
            s_tlast[s] = 1'b0; set_data(s, bval(s, 0));
            exp_cnt++;
            chk("fair_release", 64'(o_grant),   64'd0);
            chk("fair_pkt_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        end
        s_tvalid = '0;

        // Backpressure: 2000 cycles of m_tready=0 mid-packet (rr=1, src0 wraps)
        s_tvalid = 4'b0001; set_data(0, 64'hD0); m_tready = 1'b1;
        step();
        chk("bp_grant", 64'(o_grant), 64'b0001);
        chk("bp_d0",    m_tdata,      64'hD0);
        step();
        set_data(0, 64'hD1); m_tready = 1'b0;
        bad_to = 1'b0; bad_data = 1'b0; bad_rdy = 1'b0; bad_busy = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (o_timeout !== 1'b0) bad_to = 1'b1;
            if (m_tdata !== 64'hD1 || m_tvalid !== 1'b1) bad_data = 1'b1;
            if (s_tready !== 4'b0000) bad_rdy = 1'b1;
            if (o_busy !== 1'b1) bad_busy = 1'b1;
        end
        chk("bp_no_timeout", 64'(bad_to),   64'd0);
        chk("bp_data_held",  64'(bad_data), 64'd0);
        chk("bp_no_ready",   64'(bad_rdy),  64'd0);
        chk("bp_still_busy", 64'(bad_busy), 64'd0);
        m_tready = 1'b1; s_tlast[0] = 1'b1;
        #1;
        chk("bp_tlast",    64'(m_tlast),  64'd1);
        chk("bp_s_tready", 64'(s_tready), 64'b0001);
        step();
        exp_cnt++;
        chk("bp_done_busy", 64'(o_busy),    64'd0);
        chk("bp_pkt_cnt",   64'(o_pkt_cnt), 64'(exp_cnt));
        s_tvalid = '0; s_tlast = '0;

        // Stall: src2 drops tvalid after beat 1; src3 also requesting
        s_tvalid = 4'b1100; set_data(2, 64'hE0); set_data(3, 64'hF0);
        step();
        chk("stall_grant", 64'(o_grant), 64'b0100);
        chk("stall_e0",    m_tdata,      64'hE0);
        step();
        s_tvalid[2] = 1'b0;
        #1;
        chk("stall_m_tvalid", 64'(m_tvalid), 64'd0);
        bad_to = 1'b0; bad_busy = 1'b0;
        for (int c = 0; c < TMO - 1; c++) begin
            step();
            if (o_timeout !== 1'b0) bad_to = 1'b1;
            if (o_busy !== 1'b1) bad_busy = 1'b1;
        end
        chk("stall_early_timeout", 64'(bad_to),   64'd0);
        chk("stall_early_release", 64'(bad_busy), 64'd0);
        step();
        chk("stall_timeout", 64'(o_timeout), 64'd1);
        chk("stall_grant0",  64'(o_grant),   64'd0);
        chk("stall_busy0",   64'(o_busy),    64'd0);
        chk("stall_cnt",     64'(o_pkt_cnt), 64'(exp_cnt));
        s_tlast[3] = 1'b1;
        step();
        chk("stall_next_src3", 64'(o_grant),   64'b1000);
        chk("stall_pulse_end", 64'(o_timeout), 64'd0);
        chk("stall_f0",        m_tdata,        64'hF0);
        chk("stall_f0_last",   64'(m_tlast),   64'd1);
        step();
        exp_cnt++;
        chk("stall_src3_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        s_tvalid = '0; s_tlast = '0;

        // Channel drop on beat 2 of 4 (rr=0, src1)
        s_tvalid = 4'b0010; set_data(1, 64'h60);
        step();
        chk("cd_grant", 64'(o_grant), 64'b0010);
        step();
        set_data(1, 64'h61); i_channel_up = 1'b0;
        #1;
        chk("cd_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("cd_s_tready", 64'(s_tready), 64'd0);
        step();
        chk("cd_abort",   64'(o_abort),   64'd1);
        chk("cd_grant0",  64'(o_grant),   64'd0);
        chk("cd_busy0",   64'(o_busy),    64'd0);
        chk("cd_pkt_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        bad_gnt = 1'b0; bad_to = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (o_grant !== 4'b0000 || o_busy !== 1'b0) bad_gnt = 1'b1;
            if (o_abort !== 1'b0) bad_to = 1'b1;
        end
        chk("cd_no_grant_down", 64'(bad_gnt), 64'd0);
        chk("cd_abort_1cyc",    64'(bad_to),  64'd0);
        i_channel_up = 1'b1; set_data(1, 64'h70); s_tlast[1] = 1'b1;
        step();
        chk("cd_regrant", 64'(o_grant), 64'b0010);
        chk("cd_tlast",   64'(m_tlast), 64'd1);
        step();
        exp_cnt++;
        chk("cd_pkt_cnt2", 64'(o_pkt_cnt), 64'(exp_cnt));
        s_tvalid = '0; s_tlast = '0;

        // src3 in XFER while src0/src1 request (rr=2)
        s_tvalid = 4'b1000; s_tlast = 4'b1011;
        set_data(3, 64'h33); set_data(0, 64'h30); set_data(1, 64'h31);
        step();
        chk("pr_grant3", 64'(o_grant), 64'b1000);
        s_tvalid = 4'b1011;
        #1;
        chk("pr_no_preempt", 64'(s_tready), 64'b1000);
        step();
        exp_cnt++;
        chk("pr_rel3", 64'(o_grant),   64'd0);
        chk("pr_cnt3", 64'(o_pkt_cnt), 64'(exp_cnt));
        step();
        chk("pr_grant0", 64'(o_grant), 64'b0001);
        step();
        exp_cnt++;
        chk("pr_cnt0", 64'(o_pkt_cnt), 64'(exp_cnt));
        step();
`ifdef SFP_ARB_PRIO0_EN
        exp_g = 4'b0001;
`else
        exp_g = 4'b0010;
`endif
        chk("pr_ptr1_grant", 64'(o_grant), 64'(exp_g));
        step();
        exp_cnt++;
        chk("pr_cnt_last", 64'(o_pkt_cnt), 64'(exp_cnt));
        s_tvalid = '0; s_tlast = '0;

        // Reset mid-packet returns outputs to reset values immediately
        s_tvalid = 4'b0100; set_data(2, 64'h99);
        step();
        chk("mr_grant", 64'(o_grant), 64'b0100);
        i_rst = 1'b0;
        #1;
        chk("mr_m_tvalid", 64'(m_tvalid),  64'd0);
        chk("mr_s_tready", 64'(s_tready),  64'd0);
        chk("mr_grant0",   64'(o_grant),   64'd0);
        chk("mr_pkt_cnt",  64'(o_pkt_cnt), 64'd0);
        s_tvalid = '0;
        @(negedge i_clk);
        i_rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
